// File: rtl/secuenciador_red_comp.sv
// Bit-serial A>B / A==B comparator: one cell per clock, LSB first, result after N+1 cycles.
// start is taken only in IDLE; busy covers INIT..FIN and done pulses in FIN with W/igual valid.
module secuenciador_red_comp #(
    parameter int N = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [N-1:0]         a_i,
    input  logic [N-1:0]         b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 w_o,
    output logic                 igual_o,
    output logic [$clog2(N)-1:0] bit_idx_o
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_ITER = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          w_acc_q, w_acc_d;
    logic          eq_acc_q, eq_acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          w_q, w_d;
    logic          igual_q, igual_d;

    logic load_en, init_en, iter_en, commit_en, fin_en;
    logic last_bit;
    logic a_bit, b_bit;
    logic cell_w, cell_eq;

    assign last_bit = (idx_q == LAST_IDX);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_INIT;
            S_INIT:  state_d = S_ITER;
            S_ITER:  if (last_bit) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs and datapath enables ----------------
    always_comb begin
        busy_o    = 1'b0;
        done_o    = 1'b0;
        load_en   = 1'b0;
        init_en   = 1'b0;
        iter_en   = 1'b0;
        commit_en = 1'b0;
        fin_en    = 1'b0;
        case (state_q)
            S_IDLE: load_en = start_i;
            S_INIT: begin
                busy_o  = 1'b1;
                init_en = 1'b1;
            end
            S_ITER: begin
                busy_o    = 1'b1;
                iter_en   = 1'b1;
                commit_en = last_bit;
            end
            S_FIN: begin
                busy_o = 1'b1;
                done_o = 1'b1;
                fin_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Iterative cell: a strictly greater bit wins, an equal bit passes the lower verdict up.
    assign a_bit   = a_q[idx_q];
    assign b_bit   = b_q[idx_q];
    assign cell_w  = (a_bit & ~b_bit) | (~(a_bit ^ b_bit) & w_acc_q);
    assign cell_eq = eq_acc_q & ~(a_bit ^ b_bit);

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        w_acc_d  = w_acc_q;
        eq_acc_d = eq_acc_q;
        idx_d    = idx_q;
        w_d      = w_q;
        igual_d  = igual_q;
        if (load_en) begin
            a_d   = a_i;
            b_d   = b_i;
            idx_d = '0;
        end
        if (init_en) begin
            w_acc_d  = a_q[0] & ~b_q[0];
            eq_acc_d = ~(a_q[0] ^ b_q[0]);
            idx_d    = ONE_IDX;
        end
        if (iter_en) begin
            w_acc_d  = cell_w;
            eq_acc_d = cell_eq;
            if (!last_bit) begin
                idx_d = idx_q + ONE_IDX;
            end
        end
        // Results land on the edge into FIN so they are valid alongside done.
        if (commit_en) begin
            w_d     = cell_w;
            igual_d = cell_eq;
        end
        if (fin_en) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            w_acc_q  <= 1'b0;
            eq_acc_q <= 1'b0;
            idx_q    <= '0;
            w_q      <= 1'b0;
            igual_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            w_acc_q  <= w_acc_d;
            eq_acc_q <= eq_acc_d;
            idx_q    <= idx_d;
            w_q      <= w_d;
            igual_q  <= igual_d;
        end
    end

    assign w_o       = w_q;
    assign igual_o   = igual_q;
    assign bit_idx_o = idx_q;

endmodule

// File: tb/tb_secuenciador_red_comp.sv
// Bench for secuenciador_red_comp: per-cycle comparison against a phase/queue model plus directed literals.
`timescale 1ns/1ps
module tb_secuenciador_red_comp;

    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          busy;
    logic          done;
    logic          w;
    logic          igual;
    logic [IW-1:0] bit_idx;

    int checks   = 0;
    int failures = 0;

    secuenciador_red_comp #(.N(N)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (busy),
        .done_o    (done),
        .w_o       (w),
        .igual_o   (igual),
        .bit_idx_o (bit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: k = cycles since acceptance (0 = idle, N+1 = result cycle).
    int           k    = 0;
    logic         m_w  = 1'b0;
    logic         m_eq = 1'b0;
    logic [N-1:0] ma   = '0;
    logic [N-1:0] mb   = '0;
    bit           chk_en = 1'b0;
    int           dut_dones = 0;

    always @(posedge clk) begin
        if (rst) begin
            k    <= 0;
            m_w  <= 1'b0;
            m_eq <= 1'b0;
        end else if (k == 0) begin
            if (start) begin
                k  <= 1;
                ma <= a;
                mb <= b;
            end
        end else if (k == N + 1) begin
            k <= 0;
        end else begin
            k <= k + 1;
            if (k == N) begin
                m_w  <= (ma > mb);
                m_eq <= (ma == mb);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_busy_done_w_igual", {28'd0, busy, done, w, igual},
                  {28'd0, (k != 0), (k == N + 1), m_w, m_eq});
            if (k <= N) begin
                check("cycle_bit_idx", 32'(bit_idx), (k >= 2) ? 32'(k - 1) : 32'd0);
            end
            if (done) dut_dones++;
        end
    end

    // Start one comparison from an IDLE negedge and check latency and result literally.
    task automatic run_one(input logic [N-1:0] av, input logic [N-1:0] bv,
                           input logic ew, input logic eeq, input string name);
        int c;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
        end
        check({name, "_latency"}, 32'(c), 32'(N + 1));
        check({name, "_result"}, {30'd0, w, igual}, {30'd0, ew, eeq});
        @(negedge clk);
    endtask

    initial begin
        int c;
        int first_done;
        int second_done;
        logic fw, feq, sw, seq;
        int d0;
        int dones_seen;
        logic [N-1:0] ra, rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {24'd0, busy, done, w, igual, 1'b0, bit_idx},
              32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Directed cases
        run_one(8'hA5, 8'h5A, 1'b1, 1'b0, "t1_a5_5a");
        run_one(8'h3C, 8'h3C, 1'b0, 1'b1, "t2_equal");
        run_one(8'h00, 8'hFF, 1'b0, 1'b0, "t2_zero_ff");
        run_one(8'h7F, 8'h80, 1'b0, 1'b0, "t3_7f_80");
        run_one(8'h80, 8'h7F, 1'b1, 1'b0, "t3_80_7f");

        // start held high; A changes mid-run; back-to-back acceptance
        a = 8'h01;
        b = 8'h00;
        start = 1'b1;
        c = 0;
        first_done = 0;
        second_done = 0;
        fw = 1'b0; feq = 1'b0; sw = 1'b0; seq = 1'b0;
        while (second_done == 0 && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 3) a = 8'h00;
            if (done) begin
                if (first_done == 0) begin
                    first_done = c;
                    fw = w;
                    feq = igual;
                end else begin
                    second_done = c;
                    sw = w;
                    seq = igual;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("t4_first_done_cycle", 32'(first_done), 32'd9);
        check("t4_first_result", {30'd0, fw, feq}, {30'd0, 1'b1, 1'b0});
        check("t4_second_done_cycle", 32'(second_done), 32'd19);
        check("t4_second_result", {30'd0, sw, seq}, {30'd0, 1'b0, 1'b1});
        @(negedge clk);

        // Reset in cycle 4 of a run
        a = 8'hF0;
        b = 8'h0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_after_reset", {24'd0, busy, done, w, igual, 1'b0, bit_idx}, 32'd0);
        rst = 1'b0;
        dones_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones_seen++;
        end
        check("t5_no_done_after_abort", 32'(dones_seen), 32'd0);
        run_one(8'h12, 8'h34, 1'b0, 1'b0, "t5_restart");

        // Random sweep
        d0 = dut_dones;
        for (int i = 0; i < 200; i++) begin
            ra = N'($urandom);
            rb = (i % 8 == 0) ? ra : N'($urandom);
            run_one(ra, rb, (ra > rb), (ra == rb), "t6_rand");
        end
        check("t6_done_count", 32'(dut_dones - d0), 32'd200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
